// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - hazard controller signal bundle
// Ports (as interface members):
//   i_id_rs/i_id_rt/i_id_uses_rt/i_id_jump : ID-stage instruction fields
//   i_ex_mem_read/i_ex_rt/i_ex_branch_taken : ID/EX register and EX-stage status
//   i_mem_access/i_dmem_ready               : MEM-stage data-memory handshake
//   o_pc_write/o_if_id_write/o_if_id_flush/o_id_ex_flush/o_freeze : pipeline controls
//   o_mem_timeout, o_stall_count, o_flush_count                    : status
// master = pipeline side driving the inputs, slave = the controller.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       i_id_rs;
  logic [4:0]       i_id_rt;
  logic             i_id_uses_rt;
  logic             i_id_jump;
  logic             i_ex_mem_read;
  logic [4:0]       i_ex_rt;
  logic             i_ex_branch_taken;
  logic             i_mem_access;
  logic             i_dmem_ready;
  logic             o_pc_write;
  logic             o_if_id_write;
  logic             o_if_id_flush;
  logic             o_id_ex_flush;
  logic             o_freeze;
  logic             o_mem_timeout;
  logic [CNT_W-1:0] o_stall_count;
  logic [CNT_W-1:0] o_flush_count;

  modport master (
    output i_id_rs, i_id_rt, i_id_uses_rt, i_id_jump, i_ex_mem_read, i_ex_rt,
           i_ex_branch_taken, i_mem_access, i_dmem_ready,
    input  o_pc_write, o_if_id_write, o_if_id_flush, o_id_ex_flush, o_freeze,
           o_mem_timeout, o_stall_count, o_flush_count
  );

  modport slave (
    input  i_id_rs, i_id_rt, i_id_uses_rt, i_id_jump, i_ex_mem_read, i_ex_rt,
           i_ex_branch_taken, i_mem_access, i_dmem_ready,
    output o_pc_write, o_if_id_write, o_if_id_flush, o_id_ex_flush, o_freeze,
           o_mem_timeout, o_stall_count, o_flush_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - 5-stage pipeline hazard, flush and memory-wait controller
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   hz    : pipeline_hazard_ctrl_if.slave (hazard inputs, pipeline control and status outputs)
// Priority each cycle: memory freeze > taken branch > jump > load-use stall.
module pipeline_hazard_ctrl #(
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  pipeline_hazard_ctrl_if.slave  hz
);

  typedef enum logic [1:0] {RUN, LU_BUBBLE, MEM_WAIT} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic             timeout_q, timeout_d;

  logic load_use, mem_wait;
  logic stall_ev, flush_ev, timeout_hit;
  logic [8:0] wait_cnt_inc;

  assign load_use = hz.i_ex_mem_read && (hz.i_ex_rt != 5'd0) &&
                    ((hz.i_ex_rt == hz.i_id_rs) ||
                     (hz.i_id_uses_rt && (hz.i_ex_rt == hz.i_id_rt)));
  assign mem_wait = hz.i_mem_access && !hz.i_dmem_ready;

  // Count including the current frozen cycle, so the flag shows up in the
  // very cycle the limit is reached rather than one cycle later.
  assign wait_cnt_inc = {1'b0, wait_cnt_q} + 9'd1;

  always_comb begin
    state_d          = state_q;
    wait_cnt_d       = wait_cnt_q;
    stall_ev         = 1'b0;
    flush_ev         = 1'b0;
    timeout_hit      = 1'b0;
    hz.o_pc_write    = 1'b1;
    hz.o_if_id_write = 1'b1;
    hz.o_if_id_flush = 1'b0;
    hz.o_id_ex_flush = 1'b0;
    hz.o_freeze      = 1'b0;
    // While reset is held the pipeline sees plain run controls.
    if (reset) begin
      if (mem_wait) begin
        hz.o_freeze      = 1'b1;
        hz.o_pc_write    = 1'b0;
        hz.o_if_id_write = 1'b0;
        state_d          = MEM_WAIT;
        if (state_q != MEM_WAIT) begin
          wait_cnt_d = 8'd0;
        end else begin
          if (wait_cnt_q != 8'hFF) wait_cnt_d = wait_cnt_q + 8'd1;
          timeout_hit = (wait_cnt_inc >= 9'(TIMEOUT_CYCLES));
        end
      end else begin
        state_d = RUN;
        if (hz.i_ex_branch_taken) begin
          hz.o_if_id_flush = 1'b1;
          hz.o_id_ex_flush = 1'b1;
          flush_ev         = 1'b1;
        end else if (hz.i_id_jump) begin
          hz.o_if_id_flush = 1'b1;
          flush_ev         = 1'b1;
        end else if (load_use && (state_q != LU_BUBBLE)) begin
          // The bubble in EX keeps mem_read/rt, so the same match seen in
          // LU_BUBBLE is stale and must not stall a second time.
          hz.o_pc_write    = 1'b0;
          hz.o_if_id_write = 1'b0;
          hz.o_id_ex_flush = 1'b1;
          stall_ev         = 1'b1;
          state_d          = LU_BUBBLE;
        end
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_ev && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush_ev && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    timeout_d = timeout_q | timeout_hit;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      wait_cnt_q  <= 8'd0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign hz.o_mem_timeout = timeout_q | timeout_hit;
  assign hz.o_stall_count = stall_cnt_q;
  assign hz.o_flush_count = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;
  localparam int CNT_W = 4;
  localparam int TO    = 255;
  localparam int MAXC  = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [4:0] rs; logic [4:0] rt; logic uses; logic jump; logic mr;
    logic [4:0] exrt; logic br; logic acc; logic rdy;
  } in_t;

  typedef struct packed {
    in_t        in;
    logic [4:0] ctl;   // {pc_write, if_id_write, if_id_flush, id_ex_flush, freeze}
    logic [7:0] stall;
    logic [7:0] flush;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

  pipeline_hazard_ctrl #(.CNT_W(CNT_W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .hz(hz)
  );

  always #5 clk = ~clk;

  // Reference model state: history-based, not state-machine based.
  int m_stall, m_flush, m_streak;
  bit m_to, m_prev_stall;

  function automatic in_t mk(input int rs, rt, uses, jump, mr, exrt, br, acc, rdy);
    in_t v;
    v.rs = 5'(rs); v.rt = 5'(rt); v.uses = 1'(uses); v.jump = 1'(jump);
    v.mr = 1'(mr); v.exrt = 5'(exrt); v.br = 1'(br); v.acc = 1'(acc); v.rdy = 1'(rdy);
    return v;
  endfunction

  function automatic vec_t mkv(input in_t v, input logic [4:0] ctl, input int st, input int fl);
    vec_t r;
    r.in = v; r.ctl = ctl; r.stall = 8'(st); r.flush = 8'(fl);
    return r;
  endfunction

  function automatic void model_eval(input in_t v, output logic [4:0] ctl,
                                     output bit st_ev, output bit fl_ev, output bit to_now);
    bit mw, lu;
    mw = v.acc && !v.rdy;
    lu = v.mr && (v.exrt != 0) && ((v.exrt == v.rs) || (v.uses && (v.exrt == v.rt)));
    st_ev = 0; fl_ev = 0;
    if (mw)                        ctl = 5'b00001;
    else if (v.br)               begin ctl = 5'b11110; fl_ev = 1; end
    else if (v.jump)             begin ctl = 5'b11100; fl_ev = 1; end
    else if (lu && !m_prev_stall) begin ctl = 5'b00010; st_ev = 1; end
    else                           ctl = 5'b11000;
    // Flag rises once the current run of frozen cycles exceeds the limit.
    to_now = m_to || (mw && (m_streak + 1 > TO));
  endfunction

  task automatic model_reset();
    m_stall = 0; m_flush = 0; m_streak = 0; m_to = 0; m_prev_stall = 0;
  endtask

  task automatic model_commit(input in_t v);
    logic [4:0] ctl; bit st, fl, tn;
    model_eval(v, ctl, st, fl, tn);
    if (st && m_stall < MAXC) m_stall++;
    if (fl && m_flush < MAXC) m_flush++;
    m_streak     = (v.acc && !v.rdy) ? m_streak + 1 : 0;
    m_to         = tn;
    m_prev_stall = st;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] dut_ctl();
    return {hz.o_pc_write, hz.o_if_id_write, hz.o_if_id_flush, hz.o_id_ex_flush, hz.o_freeze};
  endfunction

  task automatic drive(input in_t v);
    hz.i_id_rs = v.rs; hz.i_id_rt = v.rt; hz.i_id_uses_rt = v.uses; hz.i_id_jump = v.jump;
    hz.i_ex_mem_read = v.mr; hz.i_ex_rt = v.exrt; hz.i_ex_branch_taken = v.br;
    hz.i_mem_access = v.acc; hz.i_dmem_ready = v.rdy;
  endtask

  // Called at posedge+1: drive, settle, (caller checks), then advance.
  task automatic apply(input in_t v);
    drive(v);
    #2;
  endtask

  task automatic advance(input in_t v);
    model_commit(v);
    @(posedge clk);
    #1;
  endtask

  task automatic mcycle(input in_t v, input string nm);
    logic [4:0] ctl; bit st, fl, tn;
    apply(v);
    model_eval(v, ctl, st, fl, tn);
    chk({nm, "_ctl"}, 32'(dut_ctl()), 32'(ctl));
    chk({nm, "_stall"}, 32'(hz.o_stall_count), 32'(m_stall));
    chk({nm, "_flush"}, 32'(hz.o_flush_count), 32'(m_flush));
    chk({nm, "_tout"}, 32'(hz.o_mem_timeout), 32'(tn));
    advance(v);
  endtask

  task automatic do_reset();
    drive(mk(0,0,0,0,0,0,0,0,1));
    reset = 1'b0;
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  vec_t tab [19];
  in_t  lu_in, idle_in, rv;

  initial begin
    lu_in   = mk(5,0,0,0,1,5,0,0,1);
    idle_in = mk(0,0,0,0,0,0,0,0,1);
    tab[0]  = mkv(idle_in,                    5'b11000, 0, 0);
    tab[1]  = mkv(lu_in,                      5'b00010, 0, 0);
    tab[2]  = mkv(lu_in,                      5'b11000, 1, 0);
    tab[3]  = mkv(lu_in,                      5'b00010, 1, 0);
    tab[4]  = mkv(idle_in,                    5'b11000, 2, 0);
    tab[5]  = mkv(mk(0,0,0,0,1,0,0,0,1),      5'b11000, 2, 0);
    tab[6]  = mkv(mk(0,0,1,0,1,0,0,0,1),      5'b11000, 2, 0);
    tab[7]  = mkv(mk(3,7,0,0,1,7,0,0,1),      5'b11000, 2, 0);
    tab[8]  = mkv(mk(3,7,1,0,1,7,0,0,1),      5'b00010, 2, 0);
    tab[9]  = mkv(idle_in,                    5'b11000, 3, 0);
    tab[10] = mkv(mk(5,0,0,0,1,5,1,0,1),      5'b11110, 3, 0);
    tab[11] = mkv(mk(5,0,0,1,1,5,0,0,1),      5'b11100, 3, 1);
    tab[12] = mkv(idle_in,                    5'b11000, 3, 2);
    tab[13] = mkv(mk(0,0,0,0,0,0,1,1,0),      5'b00001, 3, 2);
    tab[14] = mkv(mk(0,0,0,0,0,0,1,1,0),      5'b00001, 3, 2);
    tab[15] = mkv(mk(0,0,0,0,0,0,1,1,0),      5'b00001, 3, 2);
    tab[16] = mkv(mk(0,0,0,0,0,0,1,1,1),      5'b11110, 3, 2);
    tab[17] = mkv(idle_in,                    5'b11000, 3, 3);
    tab[18] = mkv(mk(0,0,0,0,0,0,0,0,0),      5'b11000, 3, 3);

    // Reset state, with hazard inputs present to show outputs stay at run values.
    reset = 1'b0;
    drive(idle_in);
    model_reset();
    @(posedge clk); #1;
    apply(mk(5,0,0,0,1,5,0,1,0));
    chk("rst_ctl",   32'(dut_ctl()), 32'(5'b11000));
    chk("rst_stall", 32'(hz.o_stall_count), 32'd0);
    chk("rst_flush", 32'(hz.o_flush_count), 32'd0);
    chk("rst_tout",  32'(hz.o_mem_timeout), 32'd0);
    @(posedge clk); #1;
    drive(idle_in);
    reset = 1'b1;

    // Table-driven directed vectors.
    for (int i = 0; i < 19; i++) begin
      apply(tab[i].in);
      chk($sformatf("tab%0d_ctl", i),   32'(dut_ctl()), 32'(tab[i].ctl));
      chk($sformatf("tab%0d_stall", i), 32'(hz.o_stall_count), 32'(tab[i].stall));
      chk($sformatf("tab%0d_flush", i), 32'(hz.o_flush_count), 32'(tab[i].flush));
      chk($sformatf("tab%0d_tout", i),  32'(hz.o_mem_timeout), 32'd0);
      advance(tab[i].in);
    end

    // Long memory wait: flag must rise in frozen cycle TO+1 and stay set.
    do_reset();
    for (int k = 1; k <= 300; k++) begin
      apply(mk(0,0,0,0,0,0,0,1,0));
      chk($sformatf("wait%0d_tout", k), 32'(hz.o_mem_timeout), 32'(k >= TO + 1));
      chk($sformatf("wait%0d_frz", k),  32'(hz.o_freeze), 32'd1);
      advance(mk(0,0,0,0,0,0,0,1,0));
    end
    apply(mk(0,0,0,0,0,0,0,1,1));
    chk("ready_tout", 32'(hz.o_mem_timeout), 32'd1);
    chk("ready_frz",  32'(hz.o_freeze), 32'd0);
    advance(mk(0,0,0,0,0,0,0,1,1));
    for (int k = 0; k < 3; k++) mcycle(idle_in, "post_wait");

    // Asynchronous reset in the middle of MEM_WAIT clears the sticky flag.
    for (int k = 0; k < 4; k++) mcycle(mk(0,0,0,0,0,0,0,1,0), "rewait");
    apply(mk(0,0,0,0,0,0,0,1,0));
    reset = 1'b0;
    #1;
    chk("arst_mw_tout", 32'(hz.o_mem_timeout), 32'd0);
    chk("arst_mw_ctl",  32'(dut_ctl()), 32'(5'b11000));
    model_reset();
    @(posedge clk); #1;
    drive(idle_in);
    reset = 1'b1;
    mcycle(idle_in, "after_mw_rst");

    // Counters at 3, in LU_BUBBLE, then asynchronous reset.
    do_reset();
    for (int k = 0; k < 5; k++) mcycle(lu_in, "lu_pre");
    apply(lu_in);
    chk("bub_stall", 32'(hz.o_stall_count), 32'd3);
    chk("bub_ctl",   32'(dut_ctl()), 32'(5'b11000));
    reset = 1'b0;
    #1;
    chk("arst_lu_stall", 32'(hz.o_stall_count), 32'd0);
    chk("arst_lu_ctl",   32'(dut_ctl()), 32'(5'b11000));
    model_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    apply(lu_in);
    chk("relu_ctl", 32'(dut_ctl()), 32'(5'b00010));
    advance(lu_in);
    apply(idle_in);
    chk("relu_stall", 32'(hz.o_stall_count), 32'd1);
    advance(idle_in);

    // Flush counter saturation.
    do_reset();
    for (int k = 0; k < 20; k++) mcycle(mk(0,0,0,0,0,0,1,0,1), "br_sat");
    apply(idle_in);
    chk("flush_sat", 32'(hz.o_flush_count), 32'(MAXC));
    advance(idle_in);

    // Randomized traffic against the reference model.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      rv.rs   = 5'($urandom_range(0, 3));
      rv.rt   = 5'($urandom_range(0, 3));
      rv.exrt = 5'($urandom_range(0, 3));
      rv.uses = 1'($urandom_range(0, 1));
      rv.mr   = 1'($urandom_range(0, 1));
      rv.jump = ($urandom_range(0, 7) == 0);
      rv.br   = ($urandom_range(0, 7) == 0);
      rv.acc  = ($urandom_range(0, 2) == 0);
      rv.rdy  = 1'($urandom_range(0, 1));
      mcycle(rv, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
